// File: rtl/lpf_relay_sequencer_if.sv
// Bundle of band-request, PTT and relay-drive signals between the band decoder,
// the LPF relay sequencer and the TX chain.
interface lpf_relay_sequencer_if;
    logic [6:0] lpf_req;
    logic       ptt_in;
    logic [6:0] lpf_drive;
    logic       ptt_out;
    logic       tx_inhibit;
    logic       busy;
    logic       req_err;

    modport master (
        output lpf_req, ptt_in,
        input  lpf_drive, ptt_out, tx_inhibit, busy, req_err
    );

    modport slave (
        input  lpf_req, ptt_in,
        output lpf_drive, ptt_out, tx_inhibit, busy, req_err
    );
endinterface

// File: rtl/lpf_relay_sequencer.sv
// Break-before-make LPF relay sequencer: debounces the band request, mutes TX,
// opens all relays, closes the new one and lets it settle before releasing TX.
module lpf_relay_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned MUTE_CYCLES   = 500,
    parameter int unsigned BREAK_CYCLES  = 2000,
    parameter int unsigned SETTLE_CYCLES = 4000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    lpf_relay_sequencer_if.slave  bus
);

    // A zero parameter would make a dwell vanish; clamp it to one cycle.
    localparam logic [15:0] StableEff = (STABLE_CYCLES == 0) ? 16'd1 : 16'(STABLE_CYCLES);
    localparam logic [15:0] MuteEff   = (MUTE_CYCLES   == 0) ? 16'd1 : 16'(MUTE_CYCLES);
    localparam logic [15:0] BreakEff  = (BREAK_CYCLES  == 0) ? 16'd1 : 16'(BREAK_CYCLES);
    localparam logic [15:0] SettleEff = (SETTLE_CYCLES == 0) ? 16'd1 : 16'(SETTLE_CYCLES);

    typedef enum logic [1:0] {StIdle, StMute, StBreak, StMake} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cur_q, cur_d;
    logic [6:0]  target_q, target_d;
    logic [6:0]  req_prev_q;
    logic [15:0] stab_cnt_q, stab_cnt_d;
    logic [15:0] dwell_q, dwell_d;
    logic [6:0]  drive_q, drive_d;
    logic        inhibit_q, inhibit_d;
    logic        ptt_q, ptt_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        req_valid;
    logic        prev_valid;

    assign req_valid  = $onehot(bus.lpf_req);
    assign prev_valid = $onehot(req_prev_q);

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (bus.lpf_req != req_prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != 16'hFFFF) begin
            stab_cnt_d = stab_cnt_q + 16'd1;
        end
        err_d = !req_valid && prev_valid;
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        cur_d    = cur_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                // >= rather than ==: a request that matured during a sequence
                // must still fire on the first IDLE cycle.
                if (stab_cnt_d >= StableEff && req_valid && bus.lpf_req != cur_q) begin
                    target_d = bus.lpf_req;
                    dwell_d  = '0;
                    state_d  = StMute;
                end
            end
            StMute: begin
                if (dwell_q == MuteEff - 16'd1) begin
                    dwell_d = '0;
                    state_d = StBreak;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            StBreak: begin
                if (dwell_q == BreakEff - 16'd1) begin
                    dwell_d = '0;
                    state_d = StMake;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            StMake: begin
                if (dwell_q == SettleEff - 16'd1) begin
                    dwell_d = '0;
                    cur_d   = target_q;
                    state_d = StIdle;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        drive_d = '0;
        unique case (state_d)
            StIdle:  drive_d = cur_d;
            StMute:  drive_d = cur_d;
            StBreak: drive_d = '0;
            StMake:  drive_d = target_d;
            default: drive_d = '0;
        endcase
        inhibit_d = (state_d != StIdle) || (cur_d == '0);
        busy_d    = (state_d != StIdle);
        ptt_d     = bus.ptt_in && !inhibit_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            target_q   <= '0;
            req_prev_q <= '0;
            stab_cnt_q <= '0;
            dwell_q    <= '0;
            drive_q    <= '0;
            inhibit_q  <= 1'b1;
            ptt_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            target_q   <= target_d;
            req_prev_q <= bus.lpf_req;
            stab_cnt_q <= stab_cnt_d;
            dwell_q    <= dwell_d;
            drive_q    <= drive_d;
            inhibit_q  <= inhibit_d;
            ptt_q      <= ptt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.lpf_drive  = drive_q;
    assign bus.tx_inhibit = inhibit_q;
    assign bus.ptt_out    = ptt_q;
    assign bus.busy       = busy_q;
    assign bus.req_err    = err_q;

endmodule

// File: tb/tb_lpf_relay_sequencer.sv
// Scoreboard bench: each expected relay sequence is queued when the request is
// driven and checked phase-by-phase when the sequencer returns to IDLE.
module tb_lpf_relay_sequencer;

    localparam int unsigned Stable = 4;
    localparam int unsigned Mute   = 3;
    localparam int unsigned Brk    = 5;
    localparam int unsigned Settle = 6;

    typedef struct {
        logic [6:0] old_code;
        logic [6:0] new_code;
    } seq_t;

    logic clock;
    logic reset_n;
    lpf_relay_sequencer_if bus ();

    lpf_relay_sequencer #(
        .STABLE_CYCLES (Stable),
        .MUTE_CYCLES   (Mute),
        .BREAK_CYCLES  (Brk),
        .SETTLE_CYCLES (Settle)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_unsafe = 0;
    seq_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] probe(input int which);
        case (which)
            0:       return {6'd0, bus.busy};
            1:       return {6'd0, bus.tx_inhibit};
            default: return bus.lpf_drive;
        endcase
    endfunction

    // which: 0 busy, 1 tx_inhibit, 2 lpf_drive
    task automatic wait_for(input int which, input logic [6:0] val, input int budget,
                            input string tag);
        int n = 0;
        while (probe(which) !== val && n < budget) begin
            tick(1);
            n++;
        end
        check_eq(tag, probe(which), val);
    endtask

    // Monitor: measures how many busy cycles the drive spends on old, zero and new codes.
    initial begin : monitor
        logic       active;
        logic [6:0] prev_drive;
        seq_t       cur_exp;
        seq_t       done;
        int         n_old, n_zero, n_new, n_other, n_uninh;
        active     = 1'b0;
        prev_drive = '0;
        cur_exp    = '{7'd0, 7'd0};
        n_old = 0; n_zero = 0; n_new = 0; n_other = 0; n_uninh = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                active     = 1'b0;
                prev_drive = bus.lpf_drive;
            end else if (bus.busy) begin
                if (!active) begin
                    active  = 1'b1;
                    cur_exp = (exp_q.size() > 0) ? exp_q[0] : '{prev_drive, 7'd0};
                    n_old = 0; n_zero = 0; n_new = 0; n_other = 0; n_uninh = 0;
                    check_eq("seq_start_code", prev_drive, cur_exp.old_code);
                end
                if (bus.lpf_drive == 7'd0)                  n_zero++;
                else if (bus.lpf_drive == cur_exp.old_code) n_old++;
                else if (bus.lpf_drive == cur_exp.new_code) n_new++;
                else                                        n_other++;
                if (!bus.tx_inhibit) n_uninh++;
            end else begin
                if (active) begin
                    active = 1'b0;
                    check_eq("sb_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        done = exp_q.pop_front();
                        check_eq("seq_mute_len", n_old, (done.old_code != 0) ? Mute : 0);
                        check_eq("seq_break_len", n_zero,
                                 (done.old_code != 0) ? Brk : Mute + Brk);
                        check_eq("seq_make_len", n_new, Settle);
                        check_eq("seq_other_code", n_other, 0);
                        check_eq("seq_uninhibited", n_uninh, 0);
                        check_eq("seq_final_drive", bus.lpf_drive, done.new_code);
                        check_eq("seq_final_inhibit", bus.tx_inhibit, 0);
                    end
                end
                prev_drive = bus.lpf_drive;
            end
            if (bus.ptt_out && bus.lpf_drive == 7'd0) n_unsafe++;
        end
    end

    initial begin : stimulus
        int busy_hits;
        int err_hits;
        bus.lpf_req = 7'b0000001;
        bus.ptt_in  = 1'b0;
        reset_n     = 1'b0;
        tick(3);
        check_eq("rst_drive", bus.lpf_drive, 0);
        check_eq("rst_inhibit", bus.tx_inhibit, 1);
        check_eq("rst_ptt", bus.ptt_out, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", bus.req_err, 0);

        // Power-up: first edge registers the new code, then Stable counting edges.
        exp_q.push_back('{7'd0, 7'b0000001});
        reset_n = 1'b1;
        tick(Stable);
        check_eq("pwr_busy_early", bus.busy, 0);
        tick(1);
        check_eq("pwr_busy_start", bus.busy, 1);
        wait_for(0, 7'd0, 40, "pwr_done");
        tick(2);

        // Band change while keyed: ptt_out lags tx_inhibit by one cycle both ways.
        bus.ptt_in = 1'b1;
        tick(2);
        check_eq("ptt_idle_pass", bus.ptt_out, 1);
        exp_q.push_back('{7'b0000001, 7'b0000100});
        bus.lpf_req = 7'b0000100;
        wait_for(1, 7'd1, 20, "ptt_inhibit_rise");
        check_eq("ptt_lag_hi", bus.ptt_out, 1);
        tick(1);
        check_eq("ptt_muted", bus.ptt_out, 0);
        wait_for(1, 7'd0, 40, "ptt_inhibit_fall");
        check_eq("ptt_lag_lo", bus.ptt_out, 0);
        tick(1);
        check_eq("ptt_restored", bus.ptt_out, 1);
        bus.ptt_in = 1'b0;
        tick(2);

        // Glitch shorter than the stability window is ignored.
        busy_hits = 0;
        bus.lpf_req = 7'b0000010;
        for (int i = 0; i < Stable - 1; i++) begin
            tick(1);
            if (bus.busy) busy_hits++;
        end
        bus.lpf_req = 7'b0000100;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.busy) busy_hits++;
        end
        check_eq("glitch_busy", busy_hits, 0);
        check_eq("glitch_drive", bus.lpf_drive, 7'b0000100);

        // Two bits set: one error pulse, never latched.
        busy_hits = 0;
        err_hits  = 0;
        bus.lpf_req = 7'b0000110;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.busy)    busy_hits++;
            if (bus.req_err) err_hits++;
        end
        bus.lpf_req = 7'b0000100;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.busy)    busy_hits++;
            if (bus.req_err) err_hits++;
        end
        check_eq("inval_err_pulses", err_hits, 1);
        check_eq("inval_busy", busy_hits, 0);
        check_eq("inval_drive", bus.lpf_drive, 7'b0000100);

        // New request during BREAK: target holds, second sequence follows at once.
        exp_q.push_back('{7'b0000100, 7'b0001000});
        exp_q.push_back('{7'b0001000, 7'b0100000});
        bus.lpf_req = 7'b0001000;
        wait_for(0, 7'd1, 20, "mid_busy_start");
        tick(Mute + 2);
        check_eq("mid_in_break", bus.lpf_drive, 0);
        bus.lpf_req = 7'b0100000;
        wait_for(2, 7'b0001000, 20, "mid_make_target");
        wait_for(0, 7'd0, 20, "mid_first_done");
        tick(1);
        check_eq("mid_restart", bus.busy, 1);
        wait_for(0, 7'd0, 40, "mid_second_done");
        tick(2);

        // Reset during MAKE takes effect without a clock edge.
        bus.lpf_req = 7'b0000001;
        wait_for(0, 7'd1, 20, "rmid_busy_start");
        wait_for(2, 7'b0000001, 30, "rmid_in_make");
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rmid_drive", bus.lpf_drive, 0);
        check_eq("rmid_inhibit", bus.tx_inhibit, 1);
        check_eq("rmid_ptt", bus.ptt_out, 0);
        check_eq("rmid_busy", bus.busy, 0);
        tick(2);
        exp_q.push_back('{7'd0, 7'b0000001});
        reset_n = 1'b1;
        wait_for(0, 7'd1, 20, "rrel_busy_start");
        wait_for(0, 7'd0, 40, "rrel_done");
        tick(3);

        check_eq("sb_drained", exp_q.size(), 0);
        check_eq("ptt_unsafe_cycles", n_unsafe, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lpf_relay_sequencer.md
LPF_RELAY_SEQUENCER -- requirements
Module: lpf_relay_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000: consecutive cycles lpf_req must hold before a change is acted on.
REQ-002 Parameter MUTE_CYCLES, default 500: cycles TX is inhibited before relays open.
REQ-003 Parameter BREAK_CYCLES, default 2000: cycles with all relays open (break-before-make).
REQ-004 Parameter SETTLE_CYCLES, default 4000: cycles after the new relay closes before TX is released.
REQ-005 clock  input  1  sole clock; all state on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 lpf_req  input  7  requested LPF code from the band decoder; valid only if exactly one bit set.
REQ-008 ptt_in  input  1  operator/host PTT request.
REQ-009 lpf_drive  output  7  registered relay drive to the LPF board.
REQ-010 ptt_out  output  1  registered PTT to the TX chain; ptt_in gated by inhibit.
REQ-011 tx_inhibit  output  1  registered; high while relays are unsafe.
REQ-012 busy  output  1  registered; high in any state other than IDLE.
REQ-013 req_err  output  1  registered one-cycle pulse on an invalid lpf_req.

Function
REQ-014 States SHALL be IDLE, MUTE, BREAK and MAKE; encoding is free.
REQ-015 The block SHALL hold an internal current code cur (7 bits) equal to the last code driven in MAKE.
REQ-016 A stability counter (16 bits, saturating) SHALL reset to 0 whenever lpf_req differs from its value in the previous cycle, and increment otherwise.
REQ-017 In IDLE, on the edge where the counter reaches STABLE_CYCLES with lpf_req valid and lpf_req != cur, the block SHALL latch target <= lpf_req and enter MUTE.
REQ-018 An lpf_req with zero or more than one bit set SHALL never be latched.
REQ-019 req_err SHALL pulse once on the first cycle lpf_req becomes invalid.
REQ-020 A valid lpf_req equal to cur SHALL cause no action.
REQ-021 MUTE SHALL last exactly MUTE_CYCLES cycles, with tx_inhibit=1 and lpf_drive=cur; it then goes to BREAK.
REQ-022 BREAK SHALL last exactly BREAK_CYCLES cycles, with lpf_drive=0 and tx_inhibit=1; it then goes to MAKE.
REQ-023 MAKE SHALL last exactly SETTLE_CYCLES cycles, with lpf_drive=target and tx_inhibit=1; on exit it sets cur <= target and returns to IDLE.
REQ-024 In IDLE, tx_inhibit SHALL be 0 if cur != 0, and 1 if cur == 0.
REQ-025 Changes to lpf_req during MUTE, BREAK or MAKE SHALL NOT alter target; the stability counter keeps running, so a request already stable on return to IDLE is acted on in the first IDLE cycle.
REQ-026 ptt_out SHALL equal ptt_in AND NOT tx_inhibit, registered with 1-cycle latency from both inputs; ptt_out is never 1 while lpf_drive is 0 or changing.
REQ-027 Dwell counters SHALL be 16 bits; a parameter value of 0 SHALL be treated as 1.

Reset
REQ-028 While reset_n=0 the block SHALL hold: state=IDLE, cur=0, target=0, lpf_drive=0, tx_inhibit=1, ptt_out=0, busy=0, req_err=0, counters=0.
REQ-029 Reset assertion mid-sequence SHALL immediately open all relays and inhibit TX, without completing the sequence.
REQ-030 After release of reset_n, the first stable valid lpf_req SHALL run the full MUTE/BREAK/MAKE sequence.

Verification (bench overrides: STABLE=4, MUTE=3, BREAK=5, SETTLE=6)
REQ-031 Power-up: release reset, lpf_req=7'b0000001 held -> after 4 stable cycles busy=1; lpf_drive stays 0 for 3+5 cycles, then 7'b0000001 for 6 cycles; then tx_inhibit=0 and busy=0.
REQ-032 Band change under PTT: cur=7'b0000001, ptt_in=1, lpf_req->7'b0000100 -> ptt_out falls 1 cycle after tx_inhibit rises; lpf_drive goes 0000001, then 0000000 for 5 cycles, then 0000100; ptt_out returns to 1 one cycle after tx_inhibit falls.
REQ-033 Glitch rejection: lpf_req toggles 0000010 for 3 cycles, then back to cur -> no state change, busy stays 0.
REQ-034 Invalid code: lpf_req=7'b0000110 held 20 cycles -> req_err pulses exactly once, lpf_drive unchanged, busy=0.
REQ-035 Mid-sequence request: lpf_req changes to 0100000 during BREAK toward 0001000 -> MAKE drives 0001000; on return to IDLE a second sequence to 0100000 starts in the first IDLE cycle.
REQ-036 Reset during MAKE: assert reset_n=0 -> lpf_drive=0, tx_inhibit=1 and ptt_out=0 asynchronously, with no clock edge required.
